// File: rtl/trap_request_pkg.sv
// rtl/trap_request_pkg.sv - shared types and defaults for the trap request unit
package trap_request_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUEST    = 2'd1,
    IN_HANDLER = 2'd2
  } trap_req_state_t;

  localparam int NUM_CAUSES_D = 8;
  localparam int XLEN_D       = 32;

endpackage

// File: rtl/trap_priority_encoder.sv
// rtl/trap_priority_encoder.sv - lowest-set-bit priority encoder with one-hot clear mask
module trap_priority_encoder #(
  parameter int NUM_CAUSES = 8,
  parameter int IDX_W      = 3
) (
  input  logic [NUM_CAUSES-1:0] req_i,
  output logic                  valid_o,
  output logic [IDX_W-1:0]      index_o,
  output logic [NUM_CAUSES-1:0] clear_mask_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    valid_o      = 1'b0;
    index_o      = '0;
    clear_mask_o = '0;
    for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o         = 1'b1;
        index_o         = IDX_W'(i);
        clear_mask_o    = '0;
        clear_mask_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_request_unit.sv
// rtl/trap_request_unit.sv - prioritised, registered trap request with pending latch
// Optional flush-acknowledge timeout enabled by defining TRAP_REQ_TIMEOUT_EN.
module trap_request_unit
  import trap_request_pkg::*;
#(
  parameter int NUM_CAUSES = NUM_CAUSES_D,
  parameter int XLEN       = XLEN_D,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [NUM_CAUSES-1:0]         exc_valid_i,
  input  logic [XLEN-1:0]               pc_i,
  input  logic                          flush_i,
  input  logic                          mret_i,
  output logic                          trap_taken_o,
  output logic [$clog2(NUM_CAUSES)-1:0] cause_o,
  output logic [XLEN-1:0]               epc_o,
  output logic [NUM_CAUSES-1:0]         pending_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int CW = $clog2(NUM_CAUSES);

  trap_req_state_t      state_r, state_n;
  logic [NUM_CAUSES-1:0] pending_r, pending_n;
  logic [CW-1:0]         cause_r, cause_n;
  logic [XLEN-1:0]       epc_r, epc_n;
  logic                  trap_taken_r;

  logic [NUM_CAUSES-1:0] req_vec;
  logic                  enc_valid;
  logic [CW-1:0]         enc_index;
  logic [NUM_CAUSES-1:0] enc_clear;

  assign req_vec = exc_valid_i | pending_r;

  trap_priority_encoder #(
    .NUM_CAUSES (NUM_CAUSES),
    .IDX_W      (CW)
  ) u_encoder (
    .req_i        (req_vec),
    .valid_o      (enc_valid),
    .index_o      (enc_index),
    .clear_mask_o (enc_clear)
  );

`ifdef TRAP_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] tmo_cnt_r;
  logic          tmo_expire;

  assign tmo_expire = (state_r == REQUEST) && !flush_i && (tmo_cnt_r == TW'(TIMEOUT - 1));
  assign timeout_o  = tmo_expire;

  // Held at zero outside REQUEST, so it starts from zero on every entry.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tmo_cnt_r <= '0;
    end else if (state_r != REQUEST) begin
      tmo_cnt_r <= '0;
    end else if (!flush_i) begin
      tmo_cnt_r <= tmo_cnt_r + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT;
  assign timeout_o          = 1'b0;
`endif

  always_comb begin
    state_n   = state_r;
    pending_n = pending_r;
    cause_n   = cause_r;
    epc_n     = epc_r;
    case (state_r)
      IDLE: begin
        if (enc_valid) begin
          cause_n   = enc_index;
          epc_n     = pc_i;
          pending_n = req_vec & ~enc_clear;
          state_n   = REQUEST;
        end
      end
      REQUEST: begin
        pending_n = pending_r | exc_valid_i;
        if (flush_i) begin
          state_n = IN_HANDLER;
`ifdef TRAP_REQ_TIMEOUT_EN
        end else if (tmo_expire) begin
          // Re-arm the unacknowledged cause so it is retried from IDLE.
          pending_n[cause_r] = 1'b1;
          state_n            = IDLE;
`endif
        end
      end
      IN_HANDLER: begin
        pending_n = pending_r | exc_valid_i;
        if (mret_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= IDLE;
      pending_r    <= '0;
      cause_r      <= '0;
      epc_r        <= '0;
      trap_taken_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      pending_r    <= pending_n;
      cause_r      <= cause_n;
      epc_r        <= epc_n;
      trap_taken_r <= (state_n == REQUEST);
    end
  end

  assign trap_taken_o = trap_taken_r;
  assign cause_o      = cause_r;
  assign epc_o        = epc_r;
  assign pending_o    = pending_r;
  assign busy_o       = (state_r != IDLE);

endmodule

// File: tb/tb_trap_request_unit.sv
// tb/tb_trap_request_unit.sv - directed self-checking bench for trap_request_unit
module tb_trap_request_unit;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [7:0]  exc_valid_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        mret_i;
  logic        trap_taken_o;
  logic [2:0]  cause_o;
  logic [31:0] epc_o;
  logic [7:0]  pending_o;
  logic        busy_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;
  int dropped;

  trap_request_unit #(
    .NUM_CAUSES (8),
    .XLEN       (32),
    .TIMEOUT    (4)
  ) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .exc_valid_i  (exc_valid_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .mret_i       (mret_i),
    .trap_taken_o (trap_taken_o),
    .cause_o      (cause_o),
    .epc_o        (epc_o),
    .pending_o    (pending_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_taken"},   64'(trap_taken_o), 64'd0);
    chk({tag, "_cause"},   64'(cause_o),      64'd0);
    chk({tag, "_epc"},     64'(epc_o),        64'd0);
    chk({tag, "_pending"}, 64'(pending_o),    64'd0);
    chk({tag, "_busy"},    64'(busy_o),       64'd0);
    chk({tag, "_timeout"}, 64'(timeout_o),    64'd0);
  endtask

  initial begin
    reset_i = 1'b1; exc_valid_i = '0; pc_i = '0; flush_i = 1'b0; mret_i = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    reset_i = 1'b0;
    tick();

    // Single cause 2, held until flush
    exc_valid_i = 8'b0000_0100; pc_i = 32'h8000_0010;
    tick();
    exc_valid_i = '0; pc_i = 32'h0000_1234;
    chk("t1_taken", 64'(trap_taken_o), 64'd1);
    chk("t1_cause", 64'(cause_o),      64'd2);
    chk("t1_epc",   64'(epc_o),        64'h8000_0010);
    chk("t1_busy",  64'(busy_o),       64'd1);
    tick(); tick(); tick();
    chk("t1_hold_taken", 64'(trap_taken_o), 64'd1);
    chk("t1_hold_cause", 64'(cause_o),      64'd2);
    chk("t1_hold_epc",   64'(epc_o),        64'h8000_0010);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t1_flush_taken", 64'(trap_taken_o), 64'd0);
    chk("t1_flush_busy",  64'(busy_o),       64'd1);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    chk("t1_mret_busy", 64'(busy_o), 64'd0);
    tick();
    chk("t1_idle_taken", 64'(trap_taken_o), 64'd0);

    // Flush in IDLE is ignored
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("idle_flush_busy", 64'(busy_o), 64'd0);

    // Simultaneous causes 5 and 7
    exc_valid_i = 8'b1010_0000; pc_i = 32'h0000_0100;
    tick();
    exc_valid_i = '0;
    chk("t2_cause",   64'(cause_o),   64'd5);
    chk("t2_pending", 64'(pending_o), 64'h80);
    chk("t2_epc",     64'(epc_o),     64'h100);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0; pc_i = 32'h0000_0200;
    chk("t2_r1_busy",  64'(busy_o),       64'd0);
    chk("t2_r1_taken", 64'(trap_taken_o), 64'd0);
    tick();
    chk("t2_r2_taken",   64'(trap_taken_o), 64'd1);
    chk("t2_r2_cause",   64'(cause_o),      64'd7);
    chk("t2_r2_epc",     64'(epc_o),        64'h200);
    chk("t2_r2_pending", 64'(pending_o),    64'h00);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;

    // Strobe coincident with mret is latched, issued at R+2
    exc_valid_i = 8'h01; pc_i = 32'h0000_0300;
    tick();
    exc_valid_i = '0;
    chk("t3_cause0", 64'(cause_o), 64'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    mret_i = 1'b1; exc_valid_i = 8'h02;
    tick();
    mret_i = 1'b0; exc_valid_i = '0;
    chk("t3_r1_pending", 64'(pending_o), 64'h02);
    chk("t3_r1_busy",    64'(busy_o),    64'd0);
    tick();
    chk("t3_r2_taken",   64'(trap_taken_o), 64'd1);
    chk("t3_r2_cause",   64'(cause_o),      64'd1);
    chk("t3_r2_pending", 64'(pending_o),    64'h00);

    // mret alone in REQUEST is ignored
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    chk("req_mret_taken", 64'(trap_taken_o), 64'd1);

    // flush and mret together in REQUEST: only the flush acts
    flush_i = 1'b1; mret_i = 1'b1;
    tick();
    flush_i = 1'b0; mret_i = 1'b0;
    chk("t4_taken", 64'(trap_taken_o), 64'd0);
    chk("t4_busy",  64'(busy_o),       64'd1);
    tick();
    chk("t4_still_busy", 64'(busy_o), 64'd1);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    chk("t4_mret_busy", 64'(busy_o), 64'd0);

    // Async reset in REQUEST with pending 0x0C
    exc_valid_i = 8'h0E; pc_i = 32'h0000_0400;
    tick();
    exc_valid_i = '0;
    chk("t5_cause",   64'(cause_o),   64'd1);
    chk("t5_pending", 64'(pending_o), 64'h0C);
    #2 reset_i = 1'b1;
    #1;
    chk_all_zero("t5_async");
    tick();
    reset_i = 1'b0;
    tick(); tick(); tick();
    chk_all_zero("t5_after");

    // Flush-acknowledge timeout behaviour
    exc_valid_i = 8'h08; pc_i = 32'h0000_0500;
    tick();
    exc_valid_i = '0;
    chk("t6_c1_taken", 64'(trap_taken_o), 64'd1);
    chk("t6_c1_cause", 64'(cause_o),      64'd3);
    tick(); tick(); tick();
`ifdef TRAP_REQ_TIMEOUT_EN
    chk("t6_c4_timeout", 64'(timeout_o),    64'd1);
    chk("t6_c4_taken",   64'(trap_taken_o), 64'd1);
    tick();
    chk("t6_c5_timeout", 64'(timeout_o),    64'd0);
    chk("t6_c5_taken",   64'(trap_taken_o), 64'd0);
    chk("t6_c5_pending", 64'(pending_o),    64'h08);
    chk("t6_c5_busy",    64'(busy_o),       64'd0);
    tick();
    chk("t6_c6_taken",   64'(trap_taken_o), 64'd1);
    chk("t6_c6_cause",   64'(cause_o),      64'd3);
    chk("t6_c6_pending", 64'(pending_o),    64'h00);
`else
    chk("t6_c4_timeout", 64'(timeout_o), 64'd0);
    dropped = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (trap_taken_o !== 1'b1 || timeout_o !== 1'b0) dropped++;
    end
    chk("t6_hold_100", 64'(dropped), 64'd0);
    chk("t6_hold_cause", 64'(cause_o), 64'd3);
`endif
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t6_flush_taken", 64'(trap_taken_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
